// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package mem_arb_pkg;

    // Arbiter transaction phases
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Master identifiers
    typedef enum logic {
        MST_IFU = 1'b0,
        MST_LSU = 1'b1
    } mst_id_e;

    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam int unsigned WMASK_W         = 8;

    // Timeout counter width; a disabled timeout still needs a 1-bit counter
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Winner selection between IFU and LSU requests.
// Build macro MEM_ARB_RR_EN: round-robin tie-break with a last-grant pointer;
// otherwise fixed priority with LSU winning ties and no state.
module mem_arb_picker
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic    clk,
    input  logic    rst,
    input  logic    grant_i,
`endif
    input  logic    ifu_valid_i,
    input  logic    lsu_valid_i,
    output mst_id_e winner_c
);

`ifdef MEM_ARB_RR_EN
    mst_id_e last_q;

    // Tie goes to the master not granted last; a lone requester always wins
    always_comb begin
        winner_c = MST_IFU;
        if (ifu_valid_i && lsu_valid_i) begin
            winner_c = (last_q == MST_IFU) ? MST_LSU : MST_IFU;
        end else if (lsu_valid_i) begin
            winner_c = MST_LSU;
        end
    end

    // Last-grant pointer, updated on every accepted request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= MST_IFU;
        end else if (grant_i) begin
            last_q <= winner_c;
        end
    end
`else
    // Fixed priority: LSU wins whenever it requests
    always_comb begin
        winner_c = MST_IFU;
        if (lsu_valid_i) begin
            winner_c = MST_LSU;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) single-port memory arbiter: one outstanding transaction,
// latched request, buffered response, response timeout turning a hung memory
// into an error response.
// Build macro MEM_ARB_RR_EN: round-robin tie-break (default: LSU priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    // IFU port
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    output logic                  ifu_rsp_err,
    // LSU port
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [WMASK_W-1:0]    lsu_wmask,
    output logic                  lsu_rsp_valid,
    input  logic                  lsu_rsp_ready,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  lsu_rsp_err,
    // Memory port
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic [WMASK_W-1:0]    mem_wmask,
    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    // Status
    output logic                  busy,
    output logic                  owner_lsu
);

    localparam int unsigned       CNT_W     = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT);

    arb_state_e            state_q, state_d;
    mst_id_e               owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wen_q,   wen_d;
    logic [WMASK_W-1:0]    wmask_q, wmask_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q,   err_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;

    mst_id_e               winner;
    logic                  req_grant;
    logic                  owner_rsp_ready;

    assign req_grant       = (state_q == IDLE) && (ifu_req_valid || lsu_req_valid);
    assign owner_rsp_ready = (owner_q == MST_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

    mem_arb_picker u_picker (
`ifdef MEM_ARB_RR_EN
        .clk         (clk),
        .rst         (rst),
        .grant_i     (req_grant),
`endif
        .ifu_valid_i (ifu_req_valid),
        .lsu_valid_i (lsu_req_valid),
        .winner_c    (winner)
    );

    // State and buffer registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= MST_IFU;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: request latch, memory handshake, response capture / timeout
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_grant) begin
                    owner_d = winner;
                    state_d = ISSUE;
                    if (winner == MST_LSU) begin
                        addr_d  = lsu_addr;
                        wen_d   = lsu_wen;
                        wdata_d = lsu_wdata;
                        wmask_d = lsu_wmask;
                    end else begin
                        // Fetches are always reads
                        addr_d  = ifu_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    rdata_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LIMIT)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request side: only the current winner sees ready, and only while idle
    assign ifu_req_ready = rst && (state_q == IDLE) && (winner == MST_IFU);
    assign lsu_req_ready = rst && (state_q == IDLE) && (winner == MST_LSU);

    // Memory side: responses outside WAIT are taken and dropped
    assign mem_req_valid = (state_q == ISSUE);
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wen       = wen_q;
    assign mem_wmask     = wmask_q;
    assign mem_rsp_ready = rst;

    // Response side: buffered data routed to the owning master only
    assign ifu_rsp_valid = (state_q == RESP) && (owner_q == MST_IFU);
    assign lsu_rsp_valid = (state_q == RESP) && (owner_q == MST_LSU);
    assign ifu_rdata     = rdata_q;
    assign lsu_rdata     = rdata_q;
    assign ifu_rsp_err   = err_q && (owner_q == MST_IFU);
    assign lsu_rsp_err   = err_q && (owner_q == MST_LSU);

    assign busy      = (state_q != IDLE);
    assign owner_lsu = (owner_q == MST_LSU);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, single-port memory arbiter sharing one memory interface between the instruction fetch unit and the load/store unit. It sits between the IFU and LSU and the memory model, and allows one outstanding transaction at a time. It accepts one request, forwards it downstream, buffers the response and returns it to the owning master. A response timeout turns a hung memory into an error response, so the pipeline does not deadlock.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT, 255, max cycles waiting for a memory response; 0 disables the timeout

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- ifu_req_valid  input  1  IFU read request
- ifu_req_ready  output  1  IFU request accepted
- ifu_addr  input  ADDR_WIDTH  fetch address
- ifu_rsp_valid  output  1  IFU response available
- ifu_rsp_ready  input  1  IFU takes response
- ifu_rdata  output  DATA_WIDTH  fetched word
- ifu_rsp_err  output  1  timeout error
- lsu_req_valid  input  1  LSU request
- lsu_req_ready  output  1  LSU request accepted
- lsu_addr  input  ADDR_WIDTH  data address
- lsu_wen  input  1  1 = write
- lsu_wdata  input  DATA_WIDTH  write data
- lsu_wmask  input  8  byte write mask
- lsu_rsp_valid  output  1  LSU response available
- lsu_rsp_ready  input  1  LSU takes response
- lsu_rdata  output  DATA_WIDTH  read data
- lsu_rsp_err  output  1  timeout error
- mem_req_valid  output  1  downstream request
- mem_req_ready  input  1  downstream accepts
- mem_addr, mem_wdata  output  ADDR_WIDTH / DATA_WIDTH  latched request fields
- mem_wen  output  1  latched write enable
- mem_wmask  output  8  latched write mask
- mem_rsp_valid  input  1  downstream response
- mem_rsp_ready  output  1  arbiter takes response
- mem_rdata  input  DATA_WIDTH  response data
- busy  output  1  state != IDLE
- owner_lsu  output  1  current/last owner is LSU

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - The winner's req_ready = 1 combinationally; the loser's is 0.
  - On the handshake, latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0) and the owner, then go to ISSUE.
  - With no valid request, stay in IDLE.
- **ISSUE:** mem_req_valid = 1 with the latched fields. On mem_req_ready, clear the timeout counter and go to WAIT.
- **WAIT:**
  - mem_rsp_ready = 1. On mem_rsp_valid, latch mem_rdata, set err = 0 and go to RESP.
  - Otherwise the counter increments. If TIMEOUT != 0 and the counter reaches TIMEOUT, latch rdata = 0, set err = 1 and go to RESP.
- **RESP:** the owner's rsp_valid = 1 and its rdata/err are driven from the buffer. On the owner's rsp_ready, go to IDLE. The other master's rsp_valid stays 0.
- Writes also return a response (ack); rdata carries mem_rdata unchanged.
- In IDLE/ISSUE/RESP, mem_rsp_ready = 1 and any mem_rsp_valid is dropped, which discards late responses after a timeout.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.
- Reset values: state IDLE; all valid/ready outputs, busy, err and owner_lsu = 0; latched fields and rdata = 0.
- Reset asserted mid-transaction abandons it immediately; no response is delivered.

## Timing
- Best-case latency is 3 cycles from the request handshake (cycle 0) to rsp_valid:
  - cycle 1: ISSUE with mem_req_ready high
  - cycle 2: WAIT with mem_rsp_valid high
  - cycle 3: RESP
- Back-to-back throughput is one transaction per 4 cycles (RESP→IDLE costs 1 cycle).
- Request fields may change freely after the req handshake. mem_* outputs are stable from ISSUE until the mem handshake.
- rsp_valid, once asserted, holds with stable data until rsp_ready.
- Timeout response appears TIMEOUT+1 cycles after entering WAIT.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On simultaneous requests in IDLE, grant the master not granted last.
  - The last-grant pointer resets to IFU, so the first contention goes to LSU.
  - The pointer updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority; LSU always wins a tie. No pointer register.

## Structure
- Package mem_arb_pkg:
  - state enum typedef (IDLE/ISSUE/WAIT/RESP)
  - master id enum (MST_IFU=0, MST_LSU=1)
  - default TIMEOUT constant
- Sub-module mem_arb_picker: takes both valids and returns the winner id, and owns the round-robin pointer register when MEM_ARB_RR_EN is defined.
- Top: FSM, request/response buffers, timeout counter, output muxing.

## Test plan
- IFU alone reads 0x8000_0000; mem_req_ready and mem_rsp_valid are immediate with rdata 0x1234_5678 → ifu_rsp_valid in cycle 3, ifu_rdata = 0x1234_5678, ifu_rsp_err = 0, lsu_rsp_valid stays 0.
- IFU and LSU request in the same cycle, repeated 4 times:
  - without the macro, LSU wins all 4 ties;
  - with MEM_ARB_RR_EN, grants go LSU, IFU, LSU, IFU.
- LSU write: addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0x0F, mem_req_ready delayed 5 cycles → mem_* fields stay stable throughout and an ack reaches the LSU.
- TIMEOUT=8 with no mem_rsp_valid → lsu_rsp_err = 1 and rdata = 0 nine cycles after WAIT entry; a later stray mem_rsp_valid is dropped.
- Reset: rst driven low during WAIT → busy, mem_req_valid and both rsp_valid are 0 asynchronously; after release, a new IFU request completes normally.
- Owner holds rsp_ready = 0 for 3 cycles in RESP → rsp_valid and rdata are held; new requests are not accepted until RESP exits.
